// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired Moore control sequencer driving the Datapath control inputs
module control_unit #(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [31:0] ir,
    output logic       PC_out,
    output logic       MAR_enable,
    output logic       IncPC,
    output logic       PC_enable,
    output logic       Read,
    output logic       MDR_enable,
    output logic       MDR_out,
    output logic       IR_enable,
    output logic       Gra,
    output logic       Grb,
    output logic       Grc,
    output logic       R_in,
    output logic       R_out,
    output logic       BA_out,
    output logic       Y_enable,
    output logic       C_out,
    output logic       Z_enable,
    output logic       ZLow_out,
    output logic [4:0] opcode,
    output logic       RAM_write_enable,
    output logic       run,
    output logic       illegal
);

    typedef enum logic [3:0] {
        RST_S,
        T0,
        T1,
        T2,
        T3,
        T4,
        T5,
        T6,
        T7,
        HALT_S
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);
    localparam logic [4:0] OP_ADD    = 5'b00011;
    localparam logic [4:0] OP_AND    = 5'b00101;
    localparam logic [4:0] OP_OR     = 5'b00110;

    state_t     state;
    state_t     state_next;
    logic [3:0] wait_cnt;

    logic [4:0] op;
    logic       is_ralu;
    logic       is_imm;
    logic       is_ldi;
    logic       is_ld;
    logic       is_st;
    logic       is_bd;
    logic       is_nop;
    logic       is_halt;
    logic [4:0] imm_alu_op;
    logic       unused_ir_bits;

    assign op             = ir[31:27];
    assign unused_ir_bits = ^ir[26:0];

    // Opcode class decode; only consulted from T3 onward.
    always_comb begin
        is_ralu = (op >= 5'b00011) && (op <= 5'b01011);
        is_imm  = (op >= 5'b01100) && (op <= 5'b01110);
        is_ld   = (op == 5'b00000);
        is_ldi  = (op == 5'b00001);
        is_st   = (op == 5'b00010);
        is_bd   = is_ld || is_ldi || is_st;
        is_nop  = (op == 5'b11010);
        is_halt = (op == 5'b11011);
        case (op)
            5'b01101: imm_alu_op = OP_AND;
            5'b01110: imm_alu_op = OP_OR;
            default:  imm_alu_op = OP_ADD;
        endcase
    end

    // State register and memory wait counter; the counter reloads on entry to a read state.
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= RST_S;
            wait_cnt <= 4'd0;
        end else begin
            state <= state_next;
            if ((state_next == T1 && state != T1) || (state_next == T6 && state != T6)) begin
                wait_cnt <= WAIT_INIT;
            end else if (wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // Next-state and Moore outputs from state, wait counter and opcode.
    always_comb begin
        state_next       = state;
        PC_out           = 1'b0;
        MAR_enable       = 1'b0;
        IncPC            = 1'b0;
        PC_enable        = 1'b0;
        Read             = 1'b0;
        MDR_enable       = 1'b0;
        MDR_out          = 1'b0;
        IR_enable        = 1'b0;
        Gra              = 1'b0;
        Grb              = 1'b0;
        Grc              = 1'b0;
        R_in             = 1'b0;
        R_out            = 1'b0;
        BA_out           = 1'b0;
        Y_enable         = 1'b0;
        C_out            = 1'b0;
        Z_enable         = 1'b0;
        ZLow_out         = 1'b0;
        opcode           = 5'b00000;
        RAM_write_enable = 1'b0;
        run              = 1'b1;
        illegal          = 1'b0;

        case (state)
            RST_S: begin
                run        = 1'b0;
                state_next = T0;
            end
            T0: begin
                PC_out     = 1'b1;
                MAR_enable = 1'b1;
                IncPC      = 1'b1;
                PC_enable  = 1'b1;
                state_next = T1;
            end
            T1: begin
                Read = 1'b1;
                if (wait_cnt == 4'd0) begin
                    MDR_enable = 1'b1;
                    state_next = T2;
                end
            end
            T2: begin
                MDR_out    = 1'b1;
                IR_enable  = 1'b1;
                state_next = T3;
            end
            T3: begin
                if (is_ralu || is_imm) begin
                    Grb        = 1'b1;
                    R_out      = 1'b1;
                    Y_enable   = 1'b1;
                    state_next = T4;
                end else if (is_bd) begin
                    Grb        = 1'b1;
                    BA_out     = 1'b1;
                    Y_enable   = 1'b1;
                    state_next = T4;
                end else if (is_halt) begin
                    state_next = HALT_S;
                end else if (is_nop) begin
                    state_next = T0;
                end else begin
                    illegal    = 1'b1;
                    state_next = T0;
                end
            end
            T4: begin
                Z_enable = 1'b1;
                if (is_ralu) begin
                    Grc    = 1'b1;
                    R_out  = 1'b1;
                    opcode = op;
                end else begin
                    C_out  = 1'b1;
                    opcode = is_imm ? imm_alu_op : OP_ADD;
                end
                state_next = T5;
            end
            T5: begin
                ZLow_out = 1'b1;
                if (is_ld || is_st) begin
                    MAR_enable = 1'b1;
                    state_next = T6;
                end else begin
                    Gra        = 1'b1;
                    R_in       = 1'b1;
                    state_next = T0;
                end
            end
            T6: begin
                if (is_st) begin
                    Gra        = 1'b1;
                    R_out      = 1'b1;
                    MDR_enable = 1'b1;
                    state_next = T7;
                end else begin
                    Read = 1'b1;
                    if (wait_cnt == 4'd0) begin
                        MDR_enable = 1'b1;
                        state_next = T7;
                    end
                end
            end
            T7: begin
                if (is_st) begin
                    RAM_write_enable = 1'b1;
                end else begin
                    MDR_out = 1'b1;
                    Gra     = 1'b1;
                    R_in    = 1'b1;
                end
                state_next = T0;
            end
            HALT_S: begin
                run        = 1'b0;
                state_next = HALT_S;
            end
            default: begin
                run        = 1'b0;
                state_next = RST_S;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit
module tb_control_unit;

    localparam logic [25:0] PCO = 26'd1 << 0;
    localparam logic [25:0] MAR = 26'd1 << 1;
    localparam logic [25:0] INC = 26'd1 << 2;
    localparam logic [25:0] PCE = 26'd1 << 3;
    localparam logic [25:0] RD  = 26'd1 << 4;
    localparam logic [25:0] MDE = 26'd1 << 5;
    localparam logic [25:0] MDO = 26'd1 << 6;
    localparam logic [25:0] IRE = 26'd1 << 7;
    localparam logic [25:0] GRA = 26'd1 << 8;
    localparam logic [25:0] GRB = 26'd1 << 9;
    localparam logic [25:0] GRC = 26'd1 << 10;
    localparam logic [25:0] RIN = 26'd1 << 11;
    localparam logic [25:0] ROU = 26'd1 << 12;
    localparam logic [25:0] BAO = 26'd1 << 13;
    localparam logic [25:0] YEN = 26'd1 << 14;
    localparam logic [25:0] COU = 26'd1 << 15;
    localparam logic [25:0] ZEN = 26'd1 << 16;
    localparam logic [25:0] ZLO = 26'd1 << 17;
    localparam logic [25:0] RAM = 26'd1 << 18;
    localparam logic [25:0] RUN = 26'd1 << 19;
    localparam logic [25:0] ILL = 26'd1 << 20;

    localparam logic [25:0] ZERO = 26'd0;
    localparam logic [25:0] T0V  = PCO | MAR | INC | PCE | RUN;
    localparam logic [25:0] T1W  = RD | RUN;
    localparam logic [25:0] T1F  = RD | MDE | RUN;
    localparam logic [25:0] T2V  = MDO | IRE | RUN;
    localparam logic [25:0] R3   = GRB | ROU | YEN | RUN;
    localparam logic [25:0] R4   = GRC | ROU | ZEN | RUN;
    localparam logic [25:0] R5   = ZLO | GRA | RIN | RUN;
    localparam logic [25:0] B3   = GRB | BAO | YEN | RUN;
    localparam logic [25:0] C4   = COU | ZEN | RUN;
    localparam logic [25:0] L5   = ZLO | MAR | RUN;
    localparam logic [25:0] L7   = MDO | GRA | RIN | RUN;
    localparam logic [25:0] S6   = GRA | ROU | MDE | RUN;
    localparam logic [25:0] S7   = RAM | RUN;

    logic        clk;
    logic        clr_a;
    logic        clr_b;
    logic [31:0] ir_a;
    logic [31:0] ir_b;
    bit          sel;
    wire  [25:0] act_a;
    wire  [25:0] act_b;

    logic [26:0] exp_q[$];
    string       name_q[$];
    int          checks;
    int          errors;

    control_unit #(.MEM_WAIT(0)) dut_a (
        .clk(clk), .clr(clr_a), .ir(ir_a),
        .PC_out(act_a[0]), .MAR_enable(act_a[1]), .IncPC(act_a[2]), .PC_enable(act_a[3]),
        .Read(act_a[4]), .MDR_enable(act_a[5]), .MDR_out(act_a[6]), .IR_enable(act_a[7]),
        .Gra(act_a[8]), .Grb(act_a[9]), .Grc(act_a[10]), .R_in(act_a[11]), .R_out(act_a[12]),
        .BA_out(act_a[13]), .Y_enable(act_a[14]), .C_out(act_a[15]), .Z_enable(act_a[16]),
        .ZLow_out(act_a[17]), .RAM_write_enable(act_a[18]), .run(act_a[19]),
        .illegal(act_a[20]), .opcode(act_a[25:21])
    );

    control_unit #(.MEM_WAIT(2)) dut_b (
        .clk(clk), .clr(clr_b), .ir(ir_b),
        .PC_out(act_b[0]), .MAR_enable(act_b[1]), .IncPC(act_b[2]), .PC_enable(act_b[3]),
        .Read(act_b[4]), .MDR_enable(act_b[5]), .MDR_out(act_b[6]), .IR_enable(act_b[7]),
        .Gra(act_b[8]), .Grb(act_b[9]), .Grc(act_b[10]), .R_in(act_b[11]), .R_out(act_b[12]),
        .BA_out(act_b[13]), .Y_enable(act_b[14]), .C_out(act_b[15]), .Z_enable(act_b[16]),
        .ZLow_out(act_b[17]), .RAM_write_enable(act_b[18]), .run(act_b[19]),
        .illegal(act_b[20]), .opcode(act_b[25:21])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [25:0] opf(input logic [4:0] o);
        return {o, 21'd0};
    endfunction

    // Expected outputs for the state entered on the coming posedge; called at a negedge.
    task automatic step(input logic [25:0] e, input string nm);
        exp_q.push_back({sel, e});
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    task automatic fetch(input string nm);
        if (sel) begin
            step(T1W, {nm, "_t1w0"});
            step(T1W, {nm, "_t1w1"});
        end
        step(T1F, {nm, "_t1"});
        step(T2V, {nm, "_t2"});
    endtask

    task automatic ralu(input logic [4:0] o, input string nm);
        fetch(nm);
        step(R3, {nm, "_t3"});
        step(R4 | opf(o), {nm, "_t4"});
        step(R5, {nm, "_t5"});
        step(T0V, {nm, "_t0"});
    endtask

    task automatic alu_imm(input logic [25:0] t3, input logic [4:0] o, input string nm);
        fetch(nm);
        step(t3, {nm, "_t3"});
        step(C4 | opf(o), {nm, "_t4"});
        step(R5, {nm, "_t5"});
        step(T0V, {nm, "_t0"});
    endtask

    // Monitor: compares every scheduled cycle just after the active edge.
    initial begin
        logic [26:0] ent;
        logic [25:0] act;
        string       nm;
        checks = 0;
        errors = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                ent = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = ent[26] ? act_b : act_a;
                checks++;
                if (act !== ent[25:0]) begin
                    errors++;
                    $display("FAIL %s dut_%s got %h expected %h", nm, ent[26] ? "b" : "a", act, ent[25:0]);
                end
            end
        end
    end

    initial begin
        clr_a = 1'b1;
        clr_b = 1'b1;
        ir_a  = 32'h0;
        ir_b  = 32'h0;
        sel   = 1'b0;
        @(negedge clk);

        step(ZERO, "rst0");
        step(ZERO, "rst1");
        clr_a = 1'b0;
        ir_a  = 32'h18918000;
        step(T0V, "rel_t0");
        ralu(5'b00011, "add");
        ir_a = 32'h20000000;
        ralu(5'b00100, "sub");
        ir_a = 32'h68000000;
        alu_imm(R3, 5'b00101, "andi");
        ir_a = 32'h60000000;
        alu_imm(R3, 5'b00011, "addi");
        ir_a = 32'h08000000;
        alu_imm(B3, 5'b00011, "ldi");
        ir_a = 32'hD0000000;
        fetch("nop");
        step(RUN, "nop_t3");
        step(T0V, "nop_t0");
        clr_a = 1'b1;

        sel = 1'b1;
        step(ZERO, "b_rst");
        clr_b = 1'b0;
        ir_b  = 32'h00800055;
        step(T0V, "b_t0");
        fetch("ld");
        step(B3, "ld_t3");
        step(C4 | opf(5'b00011), "ld_t4");
        step(L5, "ld_t5");
        step(T1W, "ld_t6w0");
        step(T1W, "ld_t6w1");
        step(T1F, "ld_t6");
        step(L7, "ld_t7");
        step(T0V, "ld_t0");

        ir_b = 32'h11000010;
        fetch("st");
        step(B3, "st_t3");
        step(C4 | opf(5'b00011), "st_t4");
        step(L5, "st_t5");
        step(S6, "st_t6");
        step(S7, "st_t7");
        step(T0V, "st_t0");

        ir_b = 32'h78000000;
        fetch("mul");
        step(ILL | RUN, "mul_t3");
        step(T0V, "mul_t0");

        ir_b = 32'hD8000000;
        fetch("halt");
        step(RUN, "halt_t3");
        for (int i = 0; i < 12; i++) step(ZERO, "halt_hold");
        clr_b = 1'b1;
        step(ZERO, "halt_clr");
        clr_b = 1'b0;
        step(T0V, "halt_rel_t0");

        ir_b = 32'h18918000;
        fetch("abort");
        step(R3, "abort_t3");
        step(R4 | opf(5'b00011), "abort_t4");
        clr_b = 1'b1;
        step(ZERO, "abort_clr0");
        step(ZERO, "abort_clr1");
        clr_b = 1'b0;
        step(T0V, "abort_t0");
        ralu(5'b00011, "readd");

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
